// File: rtl/arb_pkg.sv
// Shared definitions for the 4-way round-robin arbiter: requester count and FSM encoding.
package arb_pkg;

    localparam int N_REQ = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_GAP  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/arb_onehot_enc.sv
// 4-bit one-hot to 2-bit index encoder with a valid flag; index is 0 when input is all-zero.
module arb_onehot_enc
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] onehot_i,
    output logic [1:0]       idx_o,
    output logic             valid_o
);

    always_comb begin
        idx_o   = {onehot_i[3] | onehot_i[2], onehot_i[3] | onehot_i[1]};
        valid_o = |onehot_i;
    end

endmodule

// File: rtl/rr_arbiter4_en.sv
// Round-robin arbiter for 4 requesters with hold timeout, enable gating and a one-cycle
// turnaround gap between grants. Grant is registered; index/valid are decoded from it.
module rr_arbiter4_en
    import arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned CNT_W    = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             EN,
    input  logic [N_REQ-1:0] REQ,
    output logic [N_REQ-1:0] GNT,
    output logic [1:0]       GNT_ID,
    output logic             VALID,
    output logic             TIMEOUT
);

    localparam bit             HoldEn   = (MAX_HOLD != 0);
    localparam logic [CNT_W-1:0] HoldLast = HoldEn ? CNT_W'(MAX_HOLD - 1) : '0;
    localparam logic [CNT_W-1:0] HoldMax  = '1;

    arb_state_e       state_q, state_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic             timeout_q, timeout_d;

    logic [1:0]       gnt_idx;
    logic             gnt_valid;
    logic             owner_req;
    logic             expire;

    // Scan ptr, ptr+1, ... mod 4; descending loop lets the lowest offset win.
    function automatic logic [N_REQ-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                                 input logic [1:0]       ptr);
        logic [1:0] idx;
        rr_pick = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = ptr + 2'(i);
            if (req[idx]) begin
                rr_pick      = '0;
                rr_pick[idx] = 1'b1;
            end
        end
    endfunction

    arb_onehot_enc u_enc (
        .onehot_i (gnt_q),
        .idx_o    (gnt_idx),
        .valid_o  (gnt_valid)
    );

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        gnt_d      = gnt_q;
        timeout_d  = 1'b0;
        owner_req  = |(REQ & gnt_q);
        expire     = HoldEn && (hold_cnt_q == HoldLast);

        case (state_q)
            ST_BUSY: begin
                if (!owner_req || !EN || expire) begin
                    gnt_d     = '0;
                    ptr_d     = gnt_idx + 2'd1;
                    state_d   = ST_GAP;
                    // Expiry only counts as a timeout when nothing else forced the release.
                    timeout_d = expire && owner_req && EN;
                end else if (hold_cnt_q != HoldMax) begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
            end
            ST_GAP: begin
                gnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                gnt_d   = '0;
                state_d = ST_IDLE;
                if (EN && (REQ != '0)) begin
                    gnt_d      = rr_pick(REQ, ptr_q);
                    hold_cnt_d = '0;
                    state_d    = ST_BUSY;
                end
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            hold_cnt_q <= '0;
            gnt_q      <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
            gnt_q      <= gnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign GNT     = gnt_q;
    assign GNT_ID  = gnt_idx;
    assign VALID   = gnt_valid;
    assign TIMEOUT = timeout_q;

endmodule

// File: tb/tb_rr_arbiter4_en.sv
// Directed bench for rr_arbiter4_en: MAX_HOLD=8 instance for most cases, MAX_HOLD=0 instance
// for the no-timeout case. Inputs change and outputs are sampled on the falling edge.
module tb_rr_arbiter4_en;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en, en_nh;
    logic [3:0] req, req_nh;
    logic [3:0] gnt, gnt_nh;
    logic [1:0] gnt_id, gnt_id_nh;
    logic       valid, valid_nh;
    logic       timeout, timeout_nh;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rr_arbiter4_en #(.MAX_HOLD(8), .CNT_W(4)) dut (
        .CLK     (clk),
        .RST_N   (rst_n),
        .EN      (en),
        .REQ     (req),
        .GNT     (gnt),
        .GNT_ID  (gnt_id),
        .VALID   (valid),
        .TIMEOUT (timeout)
    );

    rr_arbiter4_en #(.MAX_HOLD(0), .CNT_W(4)) dut_nh (
        .CLK     (clk),
        .RST_N   (rst_n),
        .EN      (en_nh),
        .REQ     (req_nh),
        .GNT     (gnt_nh),
        .GNT_ID  (gnt_id_nh),
        .VALID   (valid_nh),
        .TIMEOUT (timeout_nh)
    );

    task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_out(input string tag, input logic [3:0] g, input logic [1:0] id,
                             input logic v, input logic to);
        check_eq({tag, ".gnt"}, 8'(gnt), 8'(g));
        check_eq({tag, ".id"}, 8'(gnt_id), 8'(id));
        check_eq({tag, ".valid"}, 8'(valid), 8'(v));
        check_eq({tag, ".timeout"}, 8'(timeout), 8'(to));
    endtask

    initial begin
        logic [3:0] order [5];
        logic       nh_bad;
        order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        rst_n  = 1'b0;
        en     = 1'b0;
        req    = 4'b0000;
        en_nh  = 1'b0;
        req_nh = 4'b0000;
        repeat (2) @(negedge clk);
        check_out("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        rst_n = 1'b1;

        // Single request, then drop: release into GAP, ptr becomes 2.
        en  = 1'b1;
        req = 4'b0010;
        @(negedge clk);
        check_out("single", 4'b0010, 2'd1, 1'b1, 1'b0);
        req = 4'b0000;
        @(negedge clk);
        check_out("single_rel", 4'b0000, 2'd0, 1'b0, 1'b0);
        @(negedge clk);

        // Grant 2, then async reset mid-grant with no clock edge.
        req = 4'b0100;
        @(negedge clk);
        check_out("pre_rst", 4'b0100, 2'd2, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1 check_out("async_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Rotation with all requests held: ptr reset to 0 means owner 0 comes first.
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_eq($sformatf("rot%0d.first", k), 8'(gnt), 8'(order[k]));
            repeat (7) @(negedge clk);
            check_eq($sformatf("rot%0d.last", k), 8'(gnt), 8'(order[k]));
            @(negedge clk);
            check_out($sformatf("rot%0d.rel", k), 4'b0000, 2'd0, 1'b0, 1'b1);
            @(negedge clk);
            check_out($sformatf("rot%0d.gap", k), 4'b0000, 2'd0, 1'b0, 1'b0);
        end
        req = 4'b0000;
        @(negedge clk);

        // Wrap-around: owner 2 released -> ptr=3, then 1001 gives 3 then 0.
        req = 4'b0100;
        @(negedge clk);
        check_eq("wrap.own2", 8'(gnt), 8'(4'b0100));
        req = 4'b0000;
        @(negedge clk);
        req = 4'b1001;
        @(negedge clk);
        @(negedge clk);
        check_out("wrap.idx3", 4'b1000, 2'd3, 1'b1, 1'b0);
        req = 4'b0001;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check_out("wrap.idx0", 4'b0001, 2'd0, 1'b1, 1'b0);
        req = 4'b0000;
        repeat (3) @(negedge clk);

        // Enable low blocks grants; dropping it mid-grant releases without TIMEOUT.
        en  = 1'b0;
        req = 4'b0100;
        repeat (3) @(negedge clk);
        check_out("en_low", 4'b0000, 2'd0, 1'b0, 1'b0);
        en = 1'b1;
        @(negedge clk);
        check_out("en_high", 4'b0100, 2'd2, 1'b1, 1'b0);
        en = 1'b0;
        @(negedge clk);
        check_out("en_drop", 4'b0000, 2'd0, 1'b0, 1'b0);
        req = 4'b0000;
        en  = 1'b1;
        repeat (2) @(negedge clk);

        // Owner drops REQ on the expiry cycle: normal release, TIMEOUT stays low.
        req = 4'b0010;
        @(negedge clk);
        check_eq("sim.gnt", 8'(gnt), 8'(4'b0010));
        repeat (7) @(negedge clk);
        check_eq("sim.held", 8'(gnt), 8'(4'b0010));
        req = 4'b0000;
        @(negedge clk);
        check_out("sim.rel", 4'b0000, 2'd0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);

        // MAX_HOLD=0: grant held indefinitely, never a TIMEOUT.
        en_nh  = 1'b1;
        req_nh = 4'b1000;
        nh_bad = 1'b0;
        @(negedge clk);
        check_eq("nohold.first", 8'(gnt_nh), 8'(4'b1000));
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (gnt_nh !== 4'b1000 || timeout_nh !== 1'b0) nh_bad = 1'b1;
        end
        check_eq("nohold.50", 8'(nh_bad), 8'(1'b0));
        check_eq("nohold.id", 8'(gnt_id_nh), 8'(2'd3));
        check_eq("nohold.valid", 8'(valid_nh), 8'(1'b1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
